// File: rtl/pcie_app_pkg.sv
// Purpose: shared PCIe application-layer constants, TX streaming sideband type and DMA write FSM states.
// Latency: none, this file holds only types and constants.
// Backpressure: none.
// Contents: FMT/TYPE codes for memory writes, block segmentation constants, tx_st_avalon_type, wr_state_e.
package pcie_app_pkg;

  localparam logic [2:0] FMT_MWR_3DW       = 3'b010;
  localparam logic [2:0] FMT_MWR_4DW       = 3'b011;
  localparam logic [4:0] TYPE_MEM          = 5'b00000;
  localparam int         TLP_PAYLOAD_BYTES = 128;
  localparam int         TLPS_PER_BLK      = 32;
  localparam int         BEATS_PER_TLP     = 5;

  // Derived values used by the DMA write path.
  localparam logic [9:0] TLP_LEN_DW        = 10'(TLP_PAYLOAD_BYTES / 4);
  localparam logic [4:0] LAST_TLP          = 5'(TLPS_PER_BLK - 1);
  // Payload beats are numbered 0..BEATS_PER_TLP-2; the header beat is not counted.
  localparam logic [1:0] LAST_PAYLOAD_BEAT = 2'(BEATS_PER_TLP - 2);

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic        valid;
    logic [1:0]  empty;
    logic        err;
    logic [31:0] parity;
  } tx_st_avalon_type;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_HDR,
    ST_DATA,
    ST_DONE
  } wr_state_e;

endpackage

// File: rtl/tx_dma_wr_hdr_build.sv
// Purpose: build the 256-bit MWr header beat (DW0 in [31:0], DW1 [63:32], DW2 [95:64], DW3 [127:96]).
// Latency: purely combinational.
// Backpressure: none; the caller decides when the beat is presented.
// Ports: addr (TLP byte address), requester_id (bus/dev/func), hdr (header beat, unused bits zero).
// Build option: TX_DMA_WR_3DW_EN selects a 3DW header when addr[63:32] is zero; otherwise always 4DW.
module tx_dma_wr_hdr_build
  import pcie_app_pkg::*;
(
  input  logic [63:0]  addr,
  input  logic [15:0]  requester_id,
  output logic [255:0] hdr
);

  logic        use_3dw;
  logic [31:0] addr_lo_dw;

  // Bits [1:0] of a DW address are reserved and always sent as zero.
  assign addr_lo_dw = addr[31:0] & 32'hFFFF_FFFC;

`ifdef TX_DMA_WR_3DW_EN
  assign use_3dw = (addr[63:32] == 32'h0);
`else
  assign use_3dw = 1'b0;
`endif

  always_comb begin
    hdr         = '0;
    hdr[31:29]  = use_3dw ? FMT_MWR_3DW : FMT_MWR_4DW;
    hdr[28:24]  = TYPE_MEM;
    hdr[9:0]    = TLP_LEN_DW;
    // DW1: requester ID, tag 0, last/first byte enables all-ones.
    hdr[63:32]  = {requester_id, 8'h00, 4'hF, 4'hF};
    if (use_3dw) begin
      hdr[95:64]  = addr_lo_dw;
    end else begin
      hdr[95:64]  = addr[63:32];
      hdr[127:96] = addr_lo_dw;
    end
  end

endmodule

// File: rtl/tx_dma_wr_tlp_gen.sv
// Purpose: split one 4KB host-write block into 32 MWr TLPs of 128B and stream them to the PCIe TX port.
// Latency: block accept -> REQ; first header beat the cycle after iGNT is sampled high; 160 beats per block.
// Backpressure: payload beats stall while iDATA_EMPTY=1 (header beats never stall); oBLK_READY only in IDLE.
// Ports: iCLK/iRST clock and async active-high reset; iBLK_* block descriptor; iREQUESTER_ID bus/dev/func;
//        iDATA/iDATA_EMPTY/oDATA_RD show-ahead payload FIFO; oREQ/iGNT TX arbiter; oTX_ST/oTX_ST_DATA beats;
//        oBLK_DONE_PULSE on final beat of the block; oLINK_NUMBER source link latched at accept.
// Build option: TX_DMA_WR_3DW_EN (see tx_dma_wr_hdr_build) enables 3DW headers below 4GB.
module tx_dma_wr_tlp_gen
  import pcie_app_pkg::*;
#(
  parameter int PORTS      = 12,
  parameter int PORT_WIDTH = $clog2(PORTS)
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iBLK_VALID,
  output logic                  oBLK_READY,
  input  logic [63:0]           iBLK_ADDR,
  input  logic [PORT_WIDTH-1:0] iBLK_LINK,
  input  logic [15:0]           iREQUESTER_ID,
  input  logic [255:0]          iDATA,
  input  logic                  iDATA_EMPTY,
  output logic                  oDATA_RD,
  output logic                  oREQ,
  input  logic                  iGNT,
  output tx_st_avalon_type      oTX_ST,
  output logic [255:0]          oTX_ST_DATA,
  output logic                  oBLK_DONE_PULSE,
  output logic [PORT_WIDTH-1:0] oLINK_NUMBER
);

  wr_state_e             state;
  wr_state_e             state_nxt;
  logic [63:0]           blk_addr;
  logic [PORT_WIDTH-1:0] link_q;
  logic [4:0]            tlp_cnt;
  logic [1:0]            beat_cnt;
  logic [63:0]           tlp_addr;
  logic [255:0]          hdr_beat;
  logic                  payload_vld;
  logic                  last_beat;

  assign payload_vld = (state == ST_DATA) && !iDATA_EMPTY;
  assign last_beat   = payload_vld && (beat_cnt == LAST_PAYLOAD_BEAT);

  // Full 64-bit add; the block is 4KB aligned so the TLP offset never carries out of bit 11.
  assign tlp_addr = blk_addr + (64'(tlp_cnt) << $clog2(TLP_PAYLOAD_BYTES));

  tx_dma_wr_hdr_build u_hdr_build (
    .addr         (tlp_addr),
    .requester_id (iREQUESTER_ID),
    .hdr          (hdr_beat)
  );

  // State register.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Descriptor latch and segmentation counters.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      blk_addr <= '0;
      link_q   <= '0;
      tlp_cnt  <= '0;
      beat_cnt <= '0;
    end else begin
      if ((state == ST_IDLE) && iBLK_VALID) begin
        blk_addr <= iBLK_ADDR;
        link_q   <= iBLK_LINK;
        tlp_cnt  <= '0;
        beat_cnt <= '0;
      end
      if (payload_vld) begin
        beat_cnt <= beat_cnt + 2'd1;
        if (last_beat) begin
          tlp_cnt <= tlp_cnt + 5'd1;
        end
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (iBLK_VALID) state_nxt = ST_REQ;
      ST_REQ:  if (iGNT) state_nxt = ST_HDR;
      ST_HDR:  state_nxt = ST_DATA;
      ST_DATA: if (last_beat) state_nxt = (tlp_cnt == LAST_TLP) ? ST_DONE : ST_HDR;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output logic. oREQ is raised already in the accepting IDLE cycle so that
  // back-to-back blocks drop the request for the single DONE cycle only.
  // iRST gates the IDLE outputs so everything reads zero while reset is held.
  always_comb begin
    oBLK_READY      = 1'b0;
    oREQ            = 1'b0;
    oDATA_RD        = 1'b0;
    oTX_ST          = '0;
    oTX_ST_DATA     = '0;
    oBLK_DONE_PULSE = 1'b0;
    case (state)
      ST_IDLE: begin
        oBLK_READY = !iRST;
        oREQ       = iBLK_VALID && !iRST;
      end
      ST_REQ: begin
        oREQ = 1'b1;
      end
      ST_HDR: begin
        oREQ         = 1'b1;
        oTX_ST.valid = 1'b1;
        oTX_ST.sop   = 1'b1;
        oTX_ST_DATA  = hdr_beat;
      end
      ST_DATA: begin
        oREQ            = 1'b1;
        oTX_ST.valid    = payload_vld;
        oTX_ST.eop      = last_beat;
        oDATA_RD        = payload_vld;
        oTX_ST_DATA     = payload_vld ? iDATA : '0;
        oBLK_DONE_PULSE = last_beat && (tlp_cnt == LAST_TLP);
      end
      default: ;
    endcase
  end

  assign oLINK_NUMBER = link_q;

endmodule

// File: tb/tb_tx_dma_wr_tlp_gen.sv
// Purpose: directed self-checking bench for tx_dma_wr_tlp_gen with a show-ahead FIFO and arbiter model.
// Latency: checks first header after grant, 160 beats per block, single-cycle request drop.
// Backpressure: injects a 3-cycle FIFO-empty stall and a 50-cycle grant delay.
module tb_tx_dma_wr_tlp_gen;
  import pcie_app_pkg::*;

  localparam int          PW  = 4;
  localparam logic [15:0] RID = 16'hBEEF;

  logic             iCLK = 1'b0;
  logic             iRST = 1'b1;
  logic             iBLK_VALID = 1'b0;
  logic             oBLK_READY;
  logic [63:0]      iBLK_ADDR = '0;
  logic [PW-1:0]    iBLK_LINK = '0;
  logic [15:0]      iREQUESTER_ID = RID;
  logic [255:0]     iDATA = '0;
  logic             iDATA_EMPTY = 1'b0;
  logic             oDATA_RD;
  logic             oREQ;
  logic             iGNT = 1'b0;
  tx_st_avalon_type oTX_ST;
  logic [255:0]     oTX_ST_DATA;
  logic             oBLK_DONE_PULSE;
  logic [PW-1:0]    oLINK_NUMBER;

  tx_dma_wr_tlp_gen #(.PORTS(12), .PORT_WIDTH(PW)) dut (
    .iCLK            (iCLK),
    .iRST            (iRST),
    .iBLK_VALID      (iBLK_VALID),
    .oBLK_READY      (oBLK_READY),
    .iBLK_ADDR       (iBLK_ADDR),
    .iBLK_LINK       (iBLK_LINK),
    .iREQUESTER_ID   (iREQUESTER_ID),
    .iDATA           (iDATA),
    .iDATA_EMPTY     (iDATA_EMPTY),
    .oDATA_RD        (oDATA_RD),
    .oREQ            (oREQ),
    .iGNT            (iGNT),
    .oTX_ST          (oTX_ST),
    .oTX_ST_DATA     (oTX_ST_DATA),
    .oBLK_DONE_PULSE (oBLK_DONE_PULSE),
    .oLINK_NUMBER    (oLINK_NUMBER)
  );

  always #5 iCLK = ~iCLK;

  int checks   = 0;
  int failures = 0;

  // Bench state: descriptor, monitor position, per-block statistics, FIFO and arbiter models.
  logic [63:0]   blk_base;
  logic [PW-1:0] blk_link;
  logic          blk_active = 0, post_eop = 0, in_block = 0, gnt_taken = 0, stall_fired = 0;
  logic          prev_ready = 0, prev_rst = 1;
  logic [PW-1:0] prev_link = '0;
  logic [255:0]  first_hdr = '0, last_hdr = '0;
  int mon_tlp = 0, mon_pos = 0, blk_beats = 0, gap = 0, pulses = 0;
  int pre_gnt_valid = 0, pre_gnt_cycles = 0, req_hole = 0, blocks_done = 0;
  int req_low_run = 0, last_low_run = 0;
  int pay_wr = 0, pay_exp = 0, stall_tlp = -1, stall_left = 0;
  int req_cnt = 0, gnt_dly = 2, exp_gap = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] pay_word(input int i);
    return {8{32'hC0DE_0000 + 32'(i)}};
  endfunction

  // Hand-packed header: DW0 0x6000_0020 (4DW MWr, 32 DW) or 0x4000_0020 (3DW), DW1 {rid, 00, FF}.
  function automatic logic [255:0] exp_hdr(input logic [63:0] a);
    logic [255:0] h;
    h = '0;
    h[63:32] = {RID, 16'h00FF};
`ifdef TX_DMA_WR_3DW_EN
    if (a[63:32] == 32'h0) begin
      h[31:0]  = 32'h4000_0020;
      h[95:64] = a[31:0];
      return h;
    end
`endif
    h[31:0]   = 32'h6000_0020;
    h[95:64]  = a[63:32];
    h[127:96] = a[31:0];
    return h;
  endfunction

  function automatic logic [63:0] hdr_addr(input logic [255:0] h);
    if (h[31:29] == 3'b011) return {h[95:64], h[127:96]};
    return {32'h0, h[95:64]};
  endfunction

  task automatic clear_stats();
    mon_tlp = 0; mon_pos = 0; blk_beats = 0; gap = 0; pulses = 0;
    pre_gnt_valid = 0; pre_gnt_cycles = 0; req_hole = 0; gnt_taken = 0; in_block = 0;
  endtask

  task automatic end_of_block();
    chk("blk_beats", blk_beats, 160);
    chk("blk_gap", gap, exp_gap);
    chk("blk_pulses", pulses, 1);
    chk("blk_pre_gnt_valid", pre_gnt_valid, 0);
    chk("blk_pre_gnt_cycles", pre_gnt_cycles, gnt_dly);
    chk("blk_req_hole", req_hole, 0);
    chk("blk_last_hdr_addr", hdr_addr(last_hdr), blk_base + 64'hF80);
    blocks_done++;
    post_eop = 1;
    clear_stats();
  endtask

  task automatic monitor();
    logic [63:0] a;
    if (oREQ && !iGNT) pre_gnt_cycles++;
    if (oTX_ST.valid && !gnt_taken) pre_gnt_valid++;
    if (oREQ && iGNT) gnt_taken = 1;
    if (post_eop) begin
      chk("req_drop_after_eop", oREQ, 0);
      chk("link_hold_done", oLINK_NUMBER, blk_link);
      post_eop = 0;
      blk_active = 0;
    end
    if (blk_active && !oREQ) req_hole++;
    if (oREQ) begin
      if (req_low_run > 0) last_low_run = req_low_run;
      req_low_run = 0;
    end else begin
      req_low_run++;
    end
    if (oLINK_NUMBER !== prev_link && !iRST && !prev_rst) chk("link_chg_idle", prev_ready, 1);
    prev_link = oLINK_NUMBER; prev_ready = oBLK_READY; prev_rst = iRST;
    if (oBLK_DONE_PULSE) pulses++;
    if (oTX_ST.valid) begin
      in_block = 1;
      blk_beats++;
      chk("side_zero", {oTX_ST.empty, oTX_ST.err, oTX_ST.parity}, 0);
      if (mon_pos == 0) begin
        chk("hdr_sop_eop", {oTX_ST.sop, oTX_ST.eop}, 2'b10);
        a = blk_base + 64'(mon_tlp) * 64'd128;
        chk("hdr", oTX_ST_DATA, exp_hdr(a));
        last_hdr = oTX_ST_DATA;
        if (mon_tlp == 0) first_hdr = oTX_ST_DATA;
      end else begin
        chk("pay_sop_eop", {oTX_ST.sop, oTX_ST.eop}, {1'b0, mon_pos == 4});
        chk("payload", oTX_ST_DATA, pay_word(pay_exp));
        pay_exp++;
      end
      chk("done_pulse", oBLK_DONE_PULSE, (mon_pos == 4 && mon_tlp == 31));
      if (mon_pos == 2 && mon_tlp == stall_tlp) begin
        stall_left = 3;
        stall_fired = 1;
      end
      if (mon_pos == 4 && mon_tlp == 31) end_of_block();
      else if (mon_pos == 4) begin mon_pos = 0; mon_tlp++; end
      else mon_pos++;
    end else begin
      chk("no_pulse_idle", oBLK_DONE_PULSE, 0);
      if (in_block) gap++;
    end
  endtask

  // One clock: sample at the falling edge, update the FIFO/arbiter models 1 time unit after the rising edge.
  task automatic cycle();
    logic acc, rd, req;
    @(negedge iCLK);
    acc = iBLK_VALID && oBLK_READY;
    rd  = oDATA_RD;
    req = oREQ;
    monitor();
    @(posedge iCLK);
    #1;
    if (rd) pay_wr++;
    iDATA = pay_word(pay_wr);
    if (acc) begin
      blk_base   = iBLK_ADDR;
      blk_link   = iBLK_LINK;
      blk_active = 1;
      pay_exp    = pay_wr;
      iBLK_VALID = 0;
    end
    if (req) req_cnt++; else req_cnt = 0;
    iGNT = req && (req_cnt >= gnt_dly);
    iDATA_EMPTY = (stall_left > 0);
    if (stall_left > 0) stall_left--;
  endtask

  task automatic post_blk(input logic [63:0] a, input logic [PW-1:0] l, input int dly, input int g);
    gnt_dly = dly; exp_gap = g;
    iBLK_ADDR = a; iBLK_LINK = l; iBLK_VALID = 1;
  endtask

  task automatic wait_blocks(input int n, input int budget);
    int k;
    k = 0;
    while (blocks_done < n && k < budget) begin
      cycle();
      k++;
    end
    chk("block_timeout", blocks_done >= n, 1);
    cycle();
  endtask

  initial begin
    int k;
    iDATA = pay_word(0);
    #3;
    chk("rst_ready", oBLK_READY, 0);
    chk("rst_req", oREQ, 0);
    chk("rst_valid", oTX_ST.valid, 0);
    chk("rst_rd", oDATA_RD, 0);
    chk("rst_link", oLINK_NUMBER, 0);
    repeat (3) @(posedge iCLK);
    #1 iRST = 0;
    #1 chk("ready_after_rst", oBLK_READY, 1);

    // Block above 4GB, FIFO never empty, grant 2 cycles after request.
    clear_stats();
    post_blk(64'h0000_0001_0000_0000, 4'd3, 2, 0);
    wait_blocks(1, 400);
    chk("t1_fmt", first_hdr[31:29], 3'b011);
    chk("t1_dw2", first_hdr[95:64], 32'h0000_0001);
    chk("t1_dw3", first_hdr[127:96], 32'h0);
    chk("t1_last_addr", hdr_addr(last_hdr), 64'h0000_0001_0000_0F80);

    // FIFO empty for 3 cycles in the middle of TLP 5's payload.
    stall_tlp = 5;
    post_blk(64'h0000_0000_1234_5000, 4'd7, 2, 3);
    wait_blocks(2, 400);
    chk("t2_stall_fired", stall_fired, 1);
    stall_tlp = -1;

    // 32-bit address: header format depends on the build option.
    post_blk(64'h0000_0000_8000_0000, 4'd1, 2, 0);
    wait_blocks(3, 400);
`ifdef TX_DMA_WR_3DW_EN
    chk("t3_dw0", first_hdr[31:0], 32'h4000_0020);
    chk("t3_dw2", first_hdr[95:64], 32'h8000_0000);
    chk("t3_dw3", first_hdr[127:96], 32'h0);
`else
    chk("t3_dw0", first_hdr[31:0], 32'h6000_0020);
    chk("t3_dw2", first_hdr[95:64], 32'h0);
    chk("t3_dw3", first_hdr[127:96], 32'h8000_0000);
`endif

    // Grant withheld for 50 cycles.
    post_blk(64'h0000_00AB_CDEF_0000, 4'd9, 50, 0);
    wait_blocks(4, 500);

    // Back-to-back blocks on different links.
    post_blk(64'h0000_0003_0000_0000, 4'd10, 2, 0);
    k = 0;
    while (iBLK_VALID && k < 20) begin cycle(); k++; end
    chk("t5_accept_a", iBLK_VALID, 0);
    post_blk(64'h0000_0003_0000_1000, 4'd11, 2, 0);
    wait_blocks(6, 800);
    chk("t5_req_low_gap", last_low_run, 1);
    chk("t5_link_b", oLINK_NUMBER, 4'd11);

    // Reset in the middle of a block.
    post_blk(64'h0000_0004_0000_0000, 4'd5, 2, 0);
    k = 0;
    while (blk_beats < 70 && k < 300) begin cycle(); k++; end
    chk("t6_reach70", blk_beats, 70);
    #2 iRST = 1;
    #1;
    chk("t6_rst_valid", oTX_ST.valid, 0);
    chk("t6_rst_req", oREQ, 0);
    chk("t6_rst_rd", oDATA_RD, 0);
    chk("t6_rst_ready", oBLK_READY, 0);
    chk("t6_rst_data", oTX_ST_DATA, 0);
    chk("t6_rst_link", oLINK_NUMBER, 0);
    clear_stats();
    blk_active = 0; post_eop = 0; iGNT = 0;
    repeat (3) cycle();
    iRST = 0;
    #1 chk("t6_ready_after_rel", oBLK_READY, 1);
    post_blk(64'h0000_0005_0000_0000, 4'd2, 2, 0);
    wait_blocks(7, 400);
    chk("t6_restart_addr", hdr_addr(first_hdr), 64'h0000_0005_0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=expired expected=finish");
    $fatal(1, "bench timeout");
  end

endmodule
